// File: rtl/updown_arb_pkg.sv
// Shared types, constants and the saturating step function for the
// round-robin arbitrated up/down counter.
package updown_arb_pkg;

    // ARB: round-robin among all requesters.
    // LOCKED: one owner holds the counter across several commands.
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Result of one saturating step.
    // hit = the command was refused because a limit was already reached.
    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } sat_res_t;

    // Single saturating step in 32-bit space.
    // The caller truncates val to its counter width.
    // Bounds are inclusive and the counter never wraps.
    function automatic sat_res_t sat_step(
        input logic [31:0] cnt,
        input logic        dir,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        sat_res_t r;
        r.hit = 1'b0;
        r.val = cnt;
        if (dir == DIR_UP) begin
            if (cnt < hi) begin
                r.val = cnt + 32'd1;
            end else begin
                r.hit = 1'b1;
            end
        end else begin
            if (cnt > lo) begin
                r.val = cnt - 32'd1;
            end else begin
                r.hit = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/updown_count_arbiter_rr_arbiter.sv
// Round-robin picker: grants the first asserted request at or after
// the pointer, wrapping past the top index.
//   i_req  : request vector
//   i_ptr  : index with highest priority this cycle
//   o_gnt  : one-hot grant (zero if no request)
//   o_idx  : index of the granted request (0 if none)
//   o_any  : at least one request is asserted
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);
    import updown_arb_pkg::*;

    localparam int IW = $clog2(NUM_REQ);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_j   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IW+1)'(NUM_REQ);
            end
            w_j = w_sum[IW-1:0];
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/updown_count_arbiter.sv
// One saturating up/down counter shared by NUM_REQ requesters through a
// round-robin arbiter, with an optional lock for multi-command sequences.
//   clk, reset      : clock, synchronous active-high reset
//   i_req_valid     : per-requester command valid
//   i_req_dir       : per-requester direction (1 = up, 0 = down)
//   i_req_lock      : requester keeps the grant after this command
//   o_req_ready     : one-hot (or zero) accept
//   o_grant_id      : index accepted this cycle (0 when none)
//   o_grant_valid   : a transfer occurs this cycle
//   o_count         : registered counter value
//   o_at_max/o_at_min : count sits on a limit
//   o_sat_err       : previous cycle's accepted command hit a limit
module updown_count_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 15,
    parameter int MIN_VAL = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ-1:0]         i_req_dir,
    input  logic [NUM_REQ-1:0]         i_req_lock,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_grant_valid,
    output logic [WIDTH-1:0]           o_count,
    output logic                       o_at_max,
    output logic                       o_at_min,
    output logic                       o_sat_err
);
    import updown_arb_pkg::*;

    localparam int IW = $clog2(NUM_REQ);

    // Registers
    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic [WIDTH-1:0] r_count;
    logic             r_sat_err;

    // Next-state and handshake wires
    state_t           w_state_nxt;
    logic [IW-1:0]    w_ptr_nxt;
    logic [IW-1:0]    w_owner_nxt;
    logic [NUM_REQ-1:0] w_ready;
    logic             w_gvalid;
    logic [IW-1:0]    w_gid;

    // Arbiter wires
    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IW-1:0]    w_arb_idx;
    logic             w_arb_any;

    // Counter step
    logic             w_dir;
    sat_res_t         w_res;
    logic             w_unused;

    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
        if (idx == IW'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + IW'(1);
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req (i_req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Handshake and next-state decode. The ready vector depends only on
    // state, pointer and valid, never on anything downstream.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_ready     = '0;
        w_gvalid    = 1'b0;
        w_gid       = '0;
        unique case (r_state)
            ARB: begin
                if (w_arb_any) begin
                    w_ready   = w_arb_gnt;
                    w_gvalid  = 1'b1;
                    w_gid     = w_arb_idx;
                    w_ptr_nxt = f_next(w_arb_idx);
                    if (i_req_lock[w_arb_idx]) begin
                        w_state_nxt = LOCKED;
                        w_owner_nxt = w_arb_idx;
                    end
                end
            end
            LOCKED: begin
                if (i_req_valid[r_owner]) begin
                    w_ready[r_owner] = 1'b1;
                    w_gvalid         = 1'b1;
                    w_gid            = r_owner;
                end
                // Dropping the lock releases the counter whether or not
                // the owner transfers this cycle. The pointer was frozen
                // during the lock and resumes just past the owner.
                if (!i_req_lock[r_owner]) begin
                    w_state_nxt = ARB;
                    w_ptr_nxt   = f_next(r_owner);
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    assign w_dir = i_req_dir[w_gid];

    assign w_res = sat_step(32'(r_count), w_dir,
                            32'(MIN_VAL), 32'(MAX_VAL));

    assign w_unused = ^w_res.val[31:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ARB;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_count   <= WIDTH'(MIN_VAL);
            r_sat_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            if (w_gvalid) begin
                r_count   <= w_res.val[WIDTH-1:0];
                r_sat_err <= w_res.hit;
            end else begin
                r_sat_err <= 1'b0;
            end
        end
    end

    assign o_req_ready   = w_ready;
    assign o_grant_valid = w_gvalid;
    assign o_grant_id    = w_gid;
    assign o_count       = r_count;
    assign o_sat_err     = r_sat_err;
    assign o_at_max      = (r_count == WIDTH'(MAX_VAL));
    assign o_at_min      = (r_count == WIDTH'(MIN_VAL));

endmodule

// File: tb/tb_updown_count_arbiter.sv
// Scoreboard bench for updown_count_arbiter: stimulus queues expected
// grants, a negedge monitor checks grant id and the count one cycle later.
module tb_updown_count_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_dir;
    logic [3:0] req_lock;
    logic [3:0] req_ready;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic [3:0] count;
    logic       at_max;
    logic       at_min;
    logic       sat_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int id;
        int cnt;
        int sat;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    bit   have_pend = 0;

    updown_count_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (4),
        .MAX_VAL (15),
        .MIN_VAL (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req_valid   (req_valid),
        .i_req_dir     (req_dir),
        .i_req_lock    (req_lock),
        .o_req_ready   (req_ready),
        .o_grant_id    (grant_id),
        .o_grant_valid (grant_valid),
        .o_count       (count),
        .o_at_max      (at_max),
        .o_at_min      (at_min),
        .o_sat_err     (sat_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic push(input int id, input int cnt, input int sat);
        exp_t e;
        e.id  = id;
        e.cnt = cnt;
        e.sat = sat;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks the grant in its cycle and the counter result
    // (count and sat_err) on the following cycle.
    always @(negedge clk) begin
        if (have_pend) begin
            chk("count_after_grant", 32'(count), 32'(pend.cnt));
            chk("sat_err_after_grant", 32'(sat_err), 32'(pend.sat));
            have_pend = 0;
        end
        if (!reset && grant_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_grant: got id %0d expected none",
                         grant_id);
            end else begin
                pend = exp_q.pop_front();
                chk("grant_id", 32'(grant_id), 32'(pend.id));
                have_pend = 1;
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_dir   = '0;
        req_lock  = '0;
        repeat (2) step();
        reset = 1'b0;

        // Reset state after idle.
        repeat (5) step();
        chk("rst_count", 32'(count), 0);
        chk("rst_at_min", 32'(at_min), 1);
        chk("rst_at_max", 32'(at_max), 0);
        chk("rst_sat_err", 32'(sat_err), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_gvalid", 32'(grant_valid), 0);

        // All valid, up: round robin 0,1,2,3,0,1,2,3.
        req_valid = 4'b1111;
        req_dir   = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            push(i % 4, i + 1, 0);
            step();
        end
        req_valid = '0;

        // Requester 0 alone climbs to 15, then one saturating up.
        req_valid = 4'b0001;
        req_dir   = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            push(0, 9 + i, 0);
        end
        push(0, 15, 1);
        repeat (8) step();
        req_valid = '0;
        step();
        chk("sat_hi_pulse_end", 32'(sat_err), 0);
        chk("sat_hi_at_max", 32'(at_max), 1);
        chk("sat_hi_count", 32'(count), 15);

        // Down to 0, then one saturating down.
        req_valid = 4'b0001;
        req_dir   = 4'b0000;
        for (int i = 0; i < 15; i++) begin
            push(0, 14 - i, 0);
        end
        push(0, 0, 1);
        repeat (16) step();
        req_valid = '0;
        step();
        chk("sat_lo_pulse_end", 32'(sat_err), 0);
        chk("sat_lo_at_min", 32'(at_min), 1);
        chk("sat_lo_count", 32'(count), 0);

        // Move pointer to 2 with one grant to requester 1.
        req_valid = 4'b0010;
        req_dir   = 4'b1111;
        push(1, 1, 0);
        step();

        // Requester 2 locks for three commands while all are valid.
        req_valid = 4'b1111;
        req_lock  = 4'b0100;
        #1 chk("lock_ready_c1", 32'(req_ready), 32'b0100);
        push(2, 2, 0);
        step();
        #1 chk("lock_ready_c2", 32'(req_ready), 32'b0100);
        push(2, 3, 0);
        step();
        req_lock = 4'b0000;
        #1 chk("lock_ready_c3", 32'(req_ready), 32'b0100);
        push(2, 4, 0);
        step();
        #1 chk("after_lock_ready", 32'(req_ready), 32'b1000);
        push(3, 5, 0);
        step();
        req_valid = '0;

        // Requester 1 takes the lock, then idles holding it.
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        push(1, 6, 0);
        step();
        req_valid = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_ready", 32'(req_ready), 0);
            chk("hold_gvalid", 32'(grant_valid), 0);
            chk("hold_count", 32'(count), 6);
            step();
        end
        // Release with owner idle: no grant this cycle.
        req_lock = 4'b0000;
        #1 chk("release_gvalid", 32'(grant_valid), 0);
        step();
        #1 chk("resume_ready", 32'(req_ready), 32'b0100);
        push(2, 7, 0);
        step();
        req_valid = '0;

        // Requester 3 locks, then reset hits with its command pending.
        req_valid = 4'b1000;
        req_lock  = 4'b1000;
        push(3, 8, 0);
        step();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_lock  = 4'b0000;
        #1;
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_at_min", 32'(at_min), 1);
        chk("post_rst_ready", 32'(req_ready), 32'b0001);
        push(0, 1, 0);
        step();
        req_valid = '0;
        repeat (3) step();

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
